// File: rtl/crack_job_loader.sv
// crack_job_loader: byte-stream front end for the password cracker array.
// Assembles a PW_LEN-character job, checks framing and charset, runs the
// cracker until found/done/timeout, then hands back one result record.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid may not depend on ready, and ready is a pure function
// of the FSM state (in_ready in LOAD, res_valid in REPORT).
module crack_job_loader #(
  parameter int PW_LEN  = 4,
  parameter int CHAR_W  = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 2**20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [CHAR_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [PW_LEN*CHAR_W-1:0] pw_out,
  output logic                     crack_rst,
  input  logic                     crack_found,
  input  logic                     crack_done,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_found,
  output logic [1:0]               res_err,
  output logic [CNT_W-1:0]         res_cycles,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

  localparam int IDX_W = (PW_LEN > 1) ? $clog2(PW_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PW_LEN - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_CHARSET = 2'b01;
  localparam logic [1:0] ERR_FRAMING = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           idx;
  logic                       cs_flag;
  logic [PW_LEN*CHAR_W-1:0]   pw;
  logic [CNT_W-1:0]           cnt;
  logic                       found_q;
  logic [1:0]                 err_q;

  logic                       in_xfer;
  logic                       last_pos;
  logic                       job_end;
  logic                       bad_char;
  logic                       framing_err;
  logic                       charset_err;
  logic [CNT_W-1:0]           cnt_inc;
  logic                       timeout_hit;

  // Byte classification, job-end detection and the saturating cycle count.
  always_comb begin
    in_xfer     = (state == S_LOAD) && in_valid;
    last_pos    = (idx == LAST_IDX);
    job_end     = in_xfer && (in_last || last_pos);
    bad_char    = !(((in_data >= CHAR_W'(8'h30)) && (in_data <= CHAR_W'(8'h39))) ||
                    ((in_data >= CHAR_W'(8'h61)) && (in_data <= CHAR_W'(8'h7a))));
    // A frame is well formed only when in_last coincides with the final slot.
    framing_err = (in_last != last_pos);
    charset_err = cs_flag || bad_char;
    cnt_inc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    timeout_hit = (cnt_inc >= TIMEOUT_C);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // FSM next-state: clean jobs go through RUN, bad jobs report directly.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD:   if (job_end) state_nxt = (framing_err || charset_err) ? S_REPORT : S_RUN;
      S_RUN:    if (crack_found || crack_done || timeout_hit) state_nxt = S_REPORT;
      S_REPORT: if (res_ready) state_nxt = S_LOAD;
      default:  state_nxt = S_LOAD;
    endcase
  end

  // Datapath: byte assembly, error capture, RUN cycle counter, result fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      cs_flag <= 1'b0;
      pw      <= '0;
      cnt     <= '0;
      found_q <= 1'b0;
      err_q   <= ERR_OK;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_xfer) begin
            for (int k = 0; k < PW_LEN; k++) begin
              if (idx == IDX_W'(k)) pw[(PW_LEN-k)*CHAR_W-1 -: CHAR_W] <= in_data;
            end
            if (job_end) begin
              idx     <= '0;
              cs_flag <= 1'b0;
              found_q <= 1'b0;
              cnt     <= '0;
              // Framing takes priority over charset.
              err_q   <= framing_err ? ERR_FRAMING :
                         charset_err ? ERR_CHARSET : ERR_OK;
            end else begin
              idx     <= idx + 1'b1;
              cs_flag <= charset_err;
            end
          end
        end
        S_RUN: begin
          cnt <= cnt_inc;
          // found beats done, and either beats a coincident timeout.
          if (crack_found) begin
            found_q <= 1'b1;
            err_q   <= ERR_OK;
          end else if (crack_done) begin
            found_q <= 1'b0;
            err_q   <= ERR_OK;
          end else if (timeout_hit) begin
            found_q <= 1'b0;
            err_q   <= ERR_TIMEOUT;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            found_q <= 1'b0;
            err_q   <= ERR_OK;
            cnt     <= '0;
            idx     <= '0;
            cs_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == S_LOAD);
  assign crack_rst  = (state != S_RUN);
  assign res_valid  = (state == S_REPORT);
  assign busy       = (state != S_LOAD);
  assign pw_out     = pw;
  assign res_found  = found_q;
  assign res_err    = err_q;
  assign res_cycles = cnt;
  assign state_dbg  = state;

endmodule

// File: tb/tb_crack_job_loader.sv
// Directed bench for crack_job_loader. Instance dut_a uses the default
// TIMEOUT; instance dut_b uses TIMEOUT=16 for the timeout cases. Both share
// inputs; sel steers in_valid and the observed outputs to one instance.
module tb_crack_job_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        crack_found = 1'b0;
  logic        crack_done = 1'b0;
  logic        res_ready = 1'b0;
  logic        sel = 1'b0;

  logic        a_in_ready, a_crack_rst, a_res_valid, a_res_found, a_busy;
  logic [31:0] a_pw_out, a_res_cycles;
  logic [1:0]  a_res_err, a_state;
  logic        b_in_ready, b_crack_rst, b_res_valid, b_res_found, b_busy;
  logic [31:0] b_pw_out, b_res_cycles;
  logic [1:0]  b_res_err, b_state;

  logic        o_in_ready, o_crack_rst, o_res_valid, o_res_found, o_busy;
  logic [31:0] o_pw_out, o_res_cycles;
  logic [1:0]  o_res_err;

  int vectors = 0;
  int miscompares = 0;

  // clock / reset block
  always #5 clk = ~clk;

  crack_job_loader dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_data(in_data), .in_last(in_last),
    .in_ready(a_in_ready), .pw_out(a_pw_out), .crack_rst(a_crack_rst),
    .crack_found(crack_found), .crack_done(crack_done), .res_valid(a_res_valid),
    .res_ready(res_ready), .res_found(a_res_found), .res_err(a_res_err),
    .res_cycles(a_res_cycles), .busy(a_busy), .state_dbg(a_state)
  );

  crack_job_loader #(.TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_data(in_data), .in_last(in_last),
    .in_ready(b_in_ready), .pw_out(b_pw_out), .crack_rst(b_crack_rst),
    .crack_found(crack_found), .crack_done(crack_done), .res_valid(b_res_valid),
    .res_ready(res_ready), .res_found(b_res_found), .res_err(b_res_err),
    .res_cycles(b_res_cycles), .busy(b_busy), .state_dbg(b_state)
  );

  always_comb begin
    o_in_ready   = sel ? b_in_ready   : a_in_ready;
    o_crack_rst  = sel ? b_crack_rst  : a_crack_rst;
    o_res_valid  = sel ? b_res_valid  : a_res_valid;
    o_res_found  = sel ? b_res_found  : a_res_found;
    o_busy       = sel ? b_busy       : a_busy;
    o_pw_out     = sel ? b_pw_out     : a_pw_out;
    o_res_cycles = sel ? b_res_cycles : a_res_cycles;
    o_res_err    = sel ? b_res_err    : a_res_err;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one job from negedge to negedge; chars holds byte 0 in the MS byte.
  task automatic send_job(input logic [31:0] chars, input int n, input int last_at);
    check("in_ready_before_job", o_in_ready, 1'b1);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = chars[31-8*k -: 8];
      in_last  = (k == last_at);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called in RUN cycle 1; raises the cracker flags during RUN cycle k.
  task automatic run_until(input int k, input logic found, input logic done);
    repeat (k - 1) @(negedge clk);
    crack_found = found;
    crack_done  = done;
    @(negedge clk);
    crack_found = 1'b0;
    crack_done  = 1'b0;
  endtask

  task automatic check_report(input string tag, input logic found, input logic [1:0] err,
                              input logic [31:0] cycles);
    check({tag, "_valid"},  o_res_valid, 1'b1);
    check({tag, "_found"},  o_res_found, found);
    check({tag, "_err"},    o_res_err, err);
    check({tag, "_cycles"}, o_res_cycles, cycles);
    check({tag, "_crst"},   o_crack_rst, 1'b1);
  endtask

  task automatic take_result(input string tag);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, "_valid_drop"}, o_res_valid, 1'b0);
    check({tag, "_idle"}, o_busy, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, o_in_ready, 1'b1);
    check({tag, "_pw"},       o_pw_out, 32'h0);
    check({tag, "_crst"},     o_crack_rst, 1'b1);
    check({tag, "_valid"},    o_res_valid, 1'b0);
    check({tag, "_found"},    o_res_found, 1'b0);
    check({tag, "_err"},      o_res_err, 2'b00);
    check({tag, "_cycles"},   o_res_cycles, 32'h0);
    check({tag, "_busy"},     o_busy, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: "ab12", found in RUN cycle 7
    send_job(32'h61623132, 4, 3);
    check("t1_pw", o_pw_out, 32'h61623132);
    check("t1_crst_low", o_crack_rst, 1'b0);
    check("t1_busy", o_busy, 1'b1);
    check("t1_in_ready_low", o_in_ready, 1'b0);
    run_until(7, 1'b1, 1'b0);
    check_report("t1", 1'b1, 2'b00, 32'd7);
    take_result("t1");

    // 2: "zzzz", done in RUN cycle 40, record held while res_ready low
    send_job(32'h7a7a7a7a, 4, 3);
    run_until(40, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check_report("t2", 1'b0, 2'b00, 32'd40);
    check("t2_pw", o_pw_out, 32'h7a7a7a7a);
    take_result("t2");

    // 3: "aB12" charset error, report on the cycle after the last byte
    send_job(32'h61423132, 4, 3);
    check_report("t3", 1'b0, 2'b01, 32'd0);
    check("t3_pw", o_pw_out, 32'h61423132);
    take_result("t3");

    // 4: "ab" short frame, stale low chars remain; then "0000" runs normally
    send_job(32'h61620000, 2, 1);
    check_report("t4", 1'b0, 2'b10, 32'd0);
    check("t4_pw_stale", o_pw_out, 32'h61623132);
    take_result("t4");
    send_job(32'h30303030, 4, 3);
    check("t4b_crst_low", o_crack_rst, 1'b0);
    run_until(1, 1'b1, 1'b0);
    check_report("t4b", 1'b1, 2'b00, 32'd1);
    take_result("t4b");

    // framing without in_last on the final byte
    send_job(32'h31323334, 4, -1);
    check_report("t4c", 1'b0, 2'b10, 32'd0);
    take_result("t4c");

    // framing beats charset: single illegal byte with in_last
    send_job(32'h41000000, 1, 0);
    check_report("t4d", 1'b0, 2'b10, 32'd0);
    take_result("t4d");

    // 5: found and done together -> found
    send_job(32'h61626364, 4, 3);
    run_until(3, 1'b1, 1'b1);
    check_report("t5a", 1'b1, 2'b00, 32'd3);
    take_result("t5a");

    // 5: timeout on the TIMEOUT=16 instance
    sel = 1'b1;
    send_job(32'h71777879, 4, 3);
    repeat (15) @(negedge clk);
    check("t5b_still_run", o_res_valid, 1'b0);
    @(negedge clk);
    check_report("t5b", 1'b0, 2'b11, 32'd16);
    take_result("t5b");

    // found in the cycle the timeout is reached wins
    send_job(32'h71777879, 4, 3);
    run_until(16, 1'b1, 1'b0);
    check_report("t5c", 1'b1, 2'b00, 32'd16);
    take_result("t5c");
    sel = 1'b0;

    // 6: reset mid-RUN
    send_job(32'h61623132, 4, 3);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("t6_run");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 6: reset mid-REPORT with res_ready low
    send_job(32'h61423132, 4, 3);
    check("t6_in_report", o_res_valid, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("t6_rep");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // clean job after resets
    send_job(32'h397a397a, 4, 3);
    check("t6_pw", o_pw_out, 32'h397a397a);
    run_until(2, 1'b1, 1'b0);
    check_report("t6", 1'b1, 2'b00, 32'd2);
    take_result("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
